// File: rtl/hbmc_tx_async_fifo.sv
`timescale 1ns/1ps
// Purpose: write-burst data CDC from clk_din to clk_dout, gray pointers, FWFT output register.
// Latency: dout_valid rises 3-4 clk_dout edges after the write edge (SYNC_STAGES=2, empty FIFO).
// Backpressure: din_ready = registered ~full; dout holds until dout_ready; wr_afull is pessimistic.
module hbmc_tx_async_fifo #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  clk_din,
  input  logic                  rst_0,
  input  logic                  clk_dout,
  input  logic                  rst_1,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  wr_afull,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_THRESH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // write-side state
  logic [PTR_W-1:0] wr_bin, wr_gray, wr_bin_nxt, wr_gray_nxt;
  logic [SYNC_STAGES-1:0][PTR_W-1:0] rd_gray_sync;
  logic [PTR_W-1:0] rd_gray_q, rd_bin_q;
  logic             wr_fire, full_nxt, afull_nxt;

  // read-side state
  logic [PTR_W-1:0] rd_bin, rd_gray, rd_bin_nxt;
  logic [SYNC_STAGES-1:0][PTR_W-1:0] wr_gray_sync;
  logic [PTR_W-1:0] wr_gray_q;
  logic             empty, rd_load;

  // Write-side next pointers and the full / almost-full decisions for the coming edge.
  always_comb begin
    wr_fire     = din_valid & din_ready;
    rd_gray_q   = rd_gray_sync[SYNC_STAGES-1];
    rd_bin_q    = gray2bin(rd_gray_q);
    wr_bin_nxt  = wr_bin + (wr_fire ? PTR_ONE : '0);
    wr_gray_nxt = bin2gray(wr_bin_nxt);
    // Full when writer is exactly one lap ahead: gray of that differs in the top two bits.
    full_nxt    = (wr_gray_nxt == {~rd_gray_q[PTR_W-1:PTR_W-2], rd_gray_q[PTR_W-3:0]});
    afull_nxt   = ((wr_bin_nxt - rd_bin_q) >= AFULL_LVL);
  end

  // Storage write port; contents intentionally left unreset.
  always_ff @(posedge clk_din) begin
    if (wr_fire) begin
      mem[wr_bin[ADDR_WIDTH-1:0]] <= din;
    end
  end

  // Write pointers, read-pointer synchroniser and registered status flags.
  always_ff @(posedge clk_din or posedge rst_0) begin
    if (rst_0) begin
      wr_bin       <= '0;
      wr_gray      <= '0;
      rd_gray_sync <= '0;
      din_ready    <= 1'b0;
      wr_afull     <= 1'b0;
    end else begin
      wr_bin       <= wr_bin_nxt;
      wr_gray      <= wr_gray_nxt;
      rd_gray_sync <= {rd_gray_sync[SYNC_STAGES-2:0], rd_gray};
      din_ready    <= ~full_nxt;
      wr_afull     <= afull_nxt;
    end
  end

  // Read-side empty detection and output-register load condition.
  always_comb begin
    wr_gray_q  = wr_gray_sync[SYNC_STAGES-1];
    empty      = (rd_gray == wr_gray_q);
    rd_load    = ~empty & (~dout_valid | dout_ready);
    rd_bin_nxt = rd_bin + PTR_ONE;
  end

  // Read pointers, write-pointer synchroniser and first-word-fall-through output register.
  always_ff @(posedge clk_dout or posedge rst_1) begin
    if (rst_1) begin
      rd_bin       <= '0;
      rd_gray      <= '0;
      wr_gray_sync <= '0;
      dout         <= '0;
      dout_valid   <= 1'b0;
    end else begin
      wr_gray_sync <= {wr_gray_sync[SYNC_STAGES-2:0], wr_gray};
      if (rd_load) begin
        dout       <= mem[rd_bin[ADDR_WIDTH-1:0]];
        dout_valid <= 1'b1;
        rd_bin     <= rd_bin_nxt;
        rd_gray    <= bin2gray(rd_bin_nxt);
      end else if (dout_valid && dout_ready) begin
        // Consumed with nothing behind it: drop valid, keep last data visible.
        dout_valid <= 1'b0;
      end
    end
  end

endmodule
